// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports and the shared memory bus seen by mem_arbiter.
// The arbiter uses the slave view; requesters and the memory model use the master view.
interface mem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  p0_valid;
    logic                  p0_write;
    logic [ADDR_WIDTH-1:0] p0_addr;
    logic [DATA_WIDTH-1:0] p0_wdata;
    logic                  p0_done;
    logic [DATA_WIDTH-1:0] p0_rdata;
    logic                  p0_err;

    logic                  p1_valid;
    logic                  p1_write;
    logic [ADDR_WIDTH-1:0] p1_addr;
    logic [DATA_WIDTH-1:0] p1_wdata;
    logic                  p1_done;
    logic [DATA_WIDTH-1:0] p1_rdata;
    logic                  p1_err;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data_in;
    logic [DATA_WIDTH-1:0] mem_data_out;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_ready;

    modport slave (
        input  p0_valid, p0_write, p0_addr, p0_wdata,
        output p0_done, p0_rdata, p0_err,
        input  p1_valid, p1_write, p1_addr, p1_wdata,
        output p1_done, p1_rdata, p1_err,
        output mem_addr, mem_data_in, mem_read, mem_write,
        input  mem_data_out, mem_ready
    );

    modport master (
        output p0_valid, p0_write, p0_addr, p0_wdata,
        input  p0_done, p0_rdata, p0_err,
        output p1_valid, p1_write, p1_addr, p1_wdata,
        input  p1_done, p1_rdata, p1_err,
        input  mem_addr, mem_data_in, mem_read, mem_write,
        output mem_data_out, mem_ready
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a single memory bus.
// One transaction in flight; hung transactions are aborted after TIMEOUT wait cycles.
module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    localparam int              CNT_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit              TIMEOUT_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q;
    logic                  last_grant_q;
    logic                  port_q;
    logic                  write_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_data_in_q;
    logic                  mem_read_q;
    logic                  mem_write_q;
    logic                  p0_done_q;
    logic                  p0_err_q;
    logic [DATA_WIDTH-1:0] p0_rdata_q;
    logic                  p1_done_q;
    logic                  p1_err_q;
    logic [DATA_WIDTH-1:0] p1_rdata_q;

    logic                  req_any_d;
    logic                  grant_d;
    logic                  write_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic [CNT_W-1:0]      cnt_d;
    logic                  timeout_d;
    logic                  finish_d;
    logic [DATA_WIDTH-1:0] resp_rdata_d;
    logic                  resp_err_d;

    // Round-robin pick: a lone requester wins, a tie goes to the port not served last.
    always_comb begin
        req_any_d = bus.p0_valid | bus.p1_valid;
        grant_d   = 1'b0;
        if (bus.p0_valid && bus.p1_valid) begin
            grant_d = ~last_grant_q;
        end else if (bus.p1_valid) begin
            grant_d = 1'b1;
        end
        write_d = grant_d ? bus.p1_write : bus.p0_write;
        addr_d  = grant_d ? bus.p1_addr  : bus.p0_addr;
        wdata_d = grant_d ? bus.p1_wdata : bus.p0_wdata;
    end

    // Ready takes priority over a timeout landing in the same cycle.
    always_comb begin
        cnt_d        = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        timeout_d    = TIMEOUT_EN && (cnt_q == CNT_LAST);
        finish_d     = bus.mem_ready | timeout_d;
        resp_err_d   = ~bus.mem_ready;
        resp_rdata_d = (bus.mem_ready && !write_q) ? bus.mem_data_out : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            port_q        <= 1'b0;
            write_q       <= 1'b0;
            cnt_q         <= '0;
            mem_addr_q    <= '0;
            mem_data_in_q <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            p0_done_q     <= 1'b0;
            p0_err_q      <= 1'b0;
            p0_rdata_q    <= '0;
            p1_done_q     <= 1'b0;
            p1_err_q      <= 1'b0;
            p1_rdata_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_any_d) begin
                        port_q        <= grant_d;
                        write_q       <= write_d;
                        mem_addr_q    <= addr_d;
                        mem_data_in_q <= wdata_d;
                        mem_read_q    <= ~write_d;
                        mem_write_q   <= write_d;
                        cnt_q         <= '0;
                        state_q       <= WAIT;
                    end
                end
                WAIT: begin
                    if (finish_d) begin
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        if (port_q) begin
                            p1_done_q  <= 1'b1;
                            p1_rdata_q <= resp_rdata_d;
                            p1_err_q   <= resp_err_d;
                        end else begin
                            p0_done_q  <= 1'b1;
                            p0_rdata_q <= resp_rdata_d;
                            p0_err_q   <= resp_err_d;
                        end
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                DONE: begin
                    p0_done_q    <= 1'b0;
                    p0_err_q     <= 1'b0;
                    p0_rdata_q   <= '0;
                    p1_done_q    <= 1'b0;
                    p1_err_q     <= 1'b0;
                    p1_rdata_q   <= '0;
                    last_grant_q <= port_q;
                    state_q      <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_data_in = mem_data_in_q;
    assign bus.mem_read    = mem_read_q;
    assign bus.mem_write   = mem_write_q;
    assign bus.p0_done     = p0_done_q;
    assign bus.p0_rdata    = p0_rdata_q;
    assign bus.p0_err      = p0_err_q;
    assign bus.p1_done     = p1_done_q;
    assign bus.p1_rdata    = p1_rdata_q;
    assign bus.p1_err      = p1_err_q;

    a_strobe_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(mem_read_q && mem_write_q));
    a_done_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(p0_done_q && p1_done_q));

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: one DUT with TIMEOUT=8 plus a TIMEOUT=4 DUT
// for the ready-versus-timeout race.
module tb_mem_arbiter;
    logic clk;
    logic rst;

    mem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();
    mem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus4 ();

    mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(4)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4)
    );

    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   mem_lat  = 1;   // ready in strobe cycle mem_lat; 0 = never ready
    int   scnt     = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    // Memory model for the main DUT, acting on the falling edge.
    always @(negedge clk) begin
        if (bus.mem_read || bus.mem_write) begin
            scnt = scnt + 1;
            bus.mem_ready    = (mem_lat != 0) && (scnt == mem_lat);
            bus.mem_data_out = bus.mem_ready ? rd_model(bus.mem_addr) : 32'hBAD0BAD0;
        end else begin
            scnt             = 0;
            bus.mem_ready    = 1'b0;
            bus.mem_data_out = 32'hBAD0BAD0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input int maxc, output bit seen, output int port,
                             output logic [31:0] rd, output logic er, output logic odone,
                             output logic [31:0] ord, output logic strb,
                             output int nstb, output int cyc);
        seen = 0; port = -1; rd = '0; er = 1'b0; odone = 1'b0; ord = '0;
        strb = 1'b0; nstb = 0; cyc = 0;
        while (!seen && cyc < maxc) begin
            tick();
            cyc++;
            if (bus.p0_done || bus.p1_done) begin
                seen  = 1;
                port  = bus.p0_done ? 0 : 1;
                rd    = (port == 1) ? bus.p1_rdata : bus.p0_rdata;
                er    = (port == 1) ? bus.p1_err   : bus.p0_err;
                odone = (port == 1) ? bus.p0_done  : bus.p1_done;
                ord   = (port == 1) ? (bus.p0_rdata | {31'b0, bus.p0_err})
                                    : (bus.p1_rdata | {31'b0, bus.p1_err});
                strb  = bus.mem_read | bus.mem_write;
            end else if (bus.mem_read || bus.mem_write) begin
                nstb++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({bus.mem_read, bus.mem_write, bus.p0_done, bus.p1_done, bus.p0_err, bus.p1_err} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000000",
                     {bus.mem_read, bus.mem_write, bus.p0_done, bus.p1_done, bus.p0_err, bus.p1_err});
        end
        checks++;
        if ({bus.mem_addr, bus.mem_data_in, bus.p0_rdata, bus.p1_rdata} !== 128'b0) begin
            failures++;
            $display("FAIL reset_buses got=%h exp=0",
                     {bus.mem_addr, bus.mem_data_in, bus.p0_rdata, bus.p1_rdata});
        end
        checks++;
        if ({bus4.mem_read, bus4.mem_write, bus4.p0_done, bus4.p1_done} !== 4'b0) begin
            failures++;
            $display("FAIL reset_dut4 got=%b exp=0000",
                     {bus4.mem_read, bus4.mem_write, bus4.p0_done, bus4.p1_done});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_read();
        exp_t e; bit seen; int port, nstb, cyc; logic [31:0] rd, ord; logic er, odn, strb;
        mem_lat = 3;
        sb.push_back('{0, rd_model(32'h100), 1'b0});
        bus.p0_write = 1'b0; bus.p0_addr = 32'h100; bus.p0_wdata = 32'hFFFFFFFF; bus.p0_valid = 1'b1;
        tick();
        checks++;
        if (bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0 || bus.mem_addr !== 32'h100) begin
            failures++;
            $display("FAIL read_strobe got rd=%b wr=%b addr=%h exp rd=1 wr=0 addr=00000100",
                     bus.mem_read, bus.mem_write, bus.mem_addr);
        end
        wait_done(40, seen, port, rd, er, odn, ord, strb, nstb, cyc);
        bus.p0_valid = 1'b0;
        e = sb.pop_front();
        checks++;
        if (!seen || port !== e.port) begin
            failures++; $display("FAIL read_port got=%0d exp=%0d", port, e.port);
        end
        checks++;
        if (rd !== e.rdata || er !== e.err) begin
            failures++; $display("FAIL read_data got=%h/%b exp=%h/%b", rd, er, e.rdata, e.err);
        end
        checks++;
        if (1 + nstb !== 3 || strb !== 1'b0) begin
            failures++; $display("FAIL read_strobe_len got=%0d/%b exp=3/0", 1 + nstb, strb);
        end
        checks++;
        if (odn !== 1'b0 || ord !== 32'h0) begin
            failures++; $display("FAIL read_other_port got=%b/%h exp=0/0", odn, ord);
        end
        tick();
        checks++;
        if (bus.p0_done !== 1'b0 || bus.p0_rdata !== 32'h0) begin
            failures++; $display("FAIL read_done_width got=%b/%h exp=0/0", bus.p0_done, bus.p0_rdata);
        end
    endtask

    task automatic test_alternation();
        exp_t e; bit seen; int port, nstb, cyc; logic [31:0] rd, ord; logic er, odn, strb;
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        mem_lat = 2;
        for (int i = 0; i < 4; i++)
            sb.push_back('{i % 2, rd_model((i % 2 == 1) ? 32'h400 : 32'h300), 1'b0});
        bus.p0_write = 1'b0; bus.p0_addr = 32'h300;
        bus.p1_write = 1'b0; bus.p1_addr = 32'h400;
        bus.p0_valid = 1'b1; bus.p1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_done(40, seen, port, rd, er, odn, ord, strb, nstb, cyc);
            if (i == 3) begin
                bus.p0_valid = 1'b0; bus.p1_valid = 1'b0;
            end
            e = sb.pop_front();
            checks++;
            if (!seen || port !== e.port || odn !== 1'b0) begin
                failures++; $display("FAIL alt_port[%0d] got=%0d/%b exp=%0d/0", i, port, odn, e.port);
            end
            checks++;
            if (rd !== e.rdata || er !== e.err) begin
                failures++; $display("FAIL alt_data[%0d] got=%h/%b exp=%h/%b", i, rd, er, e.rdata, e.err);
            end
            if (i > 0) begin
                checks++;
                if (cyc !== 4) begin
                    failures++; $display("FAIL alt_period[%0d] got=%0d exp=4", i, cyc);
                end
            end
        end
        tick(); tick();
        checks++;
        if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin
            failures++; $display("FAIL alt_no_extra_grant got=%b%b exp=00", bus.mem_read, bus.mem_write);
        end
    endtask

    task automatic test_write();
        exp_t e; bit seen; int port, nstb, cyc; logic [31:0] rd, ord; logic er, odn, strb;
        mem_lat = 2;
        sb.push_back('{1, 32'h0, 1'b0});
        bus.p1_write = 1'b1; bus.p1_addr = 32'h200; bus.p1_wdata = 32'h12345678; bus.p1_valid = 1'b1;
        tick();
        checks++;
        if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0 ||
            bus.mem_addr !== 32'h200 || bus.mem_data_in !== 32'h12345678) begin
            failures++;
            $display("FAIL write_bus got wr=%b rd=%b addr=%h data=%h exp 1 0 00000200 12345678",
                     bus.mem_write, bus.mem_read, bus.mem_addr, bus.mem_data_in);
        end
        bus.p1_valid = 1'b0;   // dropped mid-transaction; completion must still be reported
        wait_done(40, seen, port, rd, er, odn, ord, strb, nstb, cyc);
        e = sb.pop_front();
        checks++;
        if (!seen || port !== e.port) begin
            failures++; $display("FAIL write_port got=%0d exp=%0d", port, e.port);
        end
        checks++;
        if (rd !== e.rdata || er !== e.err) begin
            failures++; $display("FAIL write_rdata got=%h/%b exp=%h/%b", rd, er, e.rdata, e.err);
        end
        checks++;
        if (1 + nstb !== 2) begin
            failures++; $display("FAIL write_strobe_len got=%0d exp=2", 1 + nstb);
        end
        tick();
    endtask

    task automatic test_timeout();
        exp_t e; bit seen; int port, nstb, cyc; logic [31:0] rd, ord; logic er, odn, strb;
        mem_lat = 0;
        sb.push_back('{0, 32'h0, 1'b1});
        bus.p0_write = 1'b0; bus.p0_addr = 32'h500; bus.p0_valid = 1'b1;
        tick();
        wait_done(40, seen, port, rd, er, odn, ord, strb, nstb, cyc);
        bus.p0_valid = 1'b0;
        e = sb.pop_front();
        checks++;
        if (!seen || port !== e.port || er !== e.err || rd !== e.rdata) begin
            failures++;
            $display("FAIL timeout_resp got=%0d/%h/%b exp=%0d/%h/%b", port, rd, er, e.port, e.rdata, e.err);
        end
        checks++;
        if (1 + nstb !== 8 || strb !== 1'b0) begin
            failures++; $display("FAIL timeout_strobe_len got=%0d/%b exp=8/0", 1 + nstb, strb);
        end
        mem_lat = 2;
        sb.push_back('{1, rd_model(32'h600), 1'b0});
        bus.p1_write = 1'b0; bus.p1_addr = 32'h600; bus.p1_valid = 1'b1;
        wait_done(40, seen, port, rd, er, odn, ord, strb, nstb, cyc);
        bus.p1_valid = 1'b0;
        e = sb.pop_front();
        checks++;
        if (!seen || port !== e.port || rd !== e.rdata || er !== e.err) begin
            failures++;
            $display("FAIL timeout_next got=%0d/%h/%b exp=%0d/%h/%b", port, rd, er, e.port, e.rdata, e.err);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        exp_t e; bit seen; int port, nstb, cyc; logic [31:0] rd, ord; logic er, odn, strb;
        mem_lat = 1;
        sb.push_back('{0, 32'h0, 1'b0});
        bus.p0_write = 1'b1; bus.p0_addr = 32'h800; bus.p0_wdata = 32'h1; bus.p0_valid = 1'b1;
        wait_done(40, seen, port, rd, er, odn, ord, strb, nstb, cyc);
        bus.p0_valid = 1'b0;
        e = sb.pop_front();
        checks++;
        if (!seen || port !== e.port || rd !== e.rdata) begin
            failures++; $display("FAIL rstmid_pre got=%0d/%h exp=%0d/%h", port, rd, e.port, e.rdata);
        end
        tick();
        mem_lat = 0;
        bus.p1_write = 1'b0; bus.p1_addr = 32'h900; bus.p1_valid = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (bus.mem_read !== 1'b1) begin
            failures++; $display("FAIL rstmid_wait got=%b exp=1", bus.mem_read);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin
            failures++; $display("FAIL rstmid_async_drop got=%b%b exp=00", bus.mem_read, bus.mem_write);
        end
        bus.p1_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (bus.p0_done !== 1'b0 || bus.p1_done !== 1'b0) begin
                failures++; $display("FAIL rstmid_no_done got=%b%b exp=00", bus.p0_done, bus.p1_done);
            end
        end
        rst = 1'b0;
        tick();
        mem_lat = 2;
        sb.push_back('{0, rd_model(32'hA00), 1'b0});
        sb.push_back('{1, rd_model(32'hB00), 1'b0});
        bus.p0_write = 1'b0; bus.p0_addr = 32'hA00;
        bus.p1_write = 1'b0; bus.p1_addr = 32'hB00;
        bus.p0_valid = 1'b1; bus.p1_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wait_done(40, seen, port, rd, er, odn, ord, strb, nstb, cyc);
            if (i == 1) begin
                bus.p0_valid = 1'b0; bus.p1_valid = 1'b0;
            end
            e = sb.pop_front();
            checks++;
            if (!seen || port !== e.port || rd !== e.rdata || er !== e.err) begin
                failures++;
                $display("FAIL rstmid_tie[%0d] got=%0d/%h/%b exp=%0d/%h/%b",
                         i, port, rd, er, e.port, e.rdata, e.err);
            end
        end
        tick(); tick();
    endtask

    task automatic test_ready_on_timeout();
        exp_t e; int nstb; bit seen;
        bus4.mem_ready = 1'b1; bus4.mem_data_out = 32'h11111111;
        tick(); tick();
        checks++;
        if ({bus4.p0_done, bus4.p1_done, bus4.mem_read, bus4.mem_write} !== 4'b0) begin
            failures++;
            $display("FAIL ready_idle_ignored got=%b exp=0000",
                     {bus4.p0_done, bus4.p1_done, bus4.mem_read, bus4.mem_write});
        end
        bus4.mem_ready = 1'b0;
        sb.push_back('{0, 32'hCAFEF00D, 1'b0});
        bus4.p0_write = 1'b0; bus4.p0_addr = 32'h700; bus4.p0_valid = 1'b1;
        nstb = 0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (bus4.mem_read) nstb++;
            if (k == 4) begin
                bus4.mem_ready = 1'b1; bus4.mem_data_out = 32'hCAFEF00D;
            end
        end
        tick();
        bus4.mem_ready = 1'b0; bus4.mem_data_out = 32'hBAD0BAD0; bus4.p0_valid = 1'b0;
        e = sb.pop_front();
        checks++;
        if (nstb !== 4) begin
            failures++; $display("FAIL race_strobe_len got=%0d exp=4", nstb);
        end
        checks++;
        if (bus4.p0_done !== 1'b1 || bus4.p0_rdata !== e.rdata || bus4.p0_err !== e.err) begin
            failures++;
            $display("FAIL race_ready_wins got=%b/%h/%b exp=1/%h/%b",
                     bus4.p0_done, bus4.p0_rdata, bus4.p0_err, e.rdata, e.err);
        end
        tick();
        sb.push_back('{1, 32'h0, 1'b1});
        bus4.p1_write = 1'b0; bus4.p1_addr = 32'h710; bus4.p1_valid = 1'b1;
        nstb = 0; seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            if (bus4.p1_done) seen = 1;
            else if (bus4.mem_read) nstb++;
        end
        bus4.p1_valid = 1'b0;
        e = sb.pop_front();
        checks++;
        if (!seen || nstb !== 4 || bus4.p1_err !== e.err || bus4.p1_rdata !== e.rdata) begin
            failures++;
            $display("FAIL race_plain_timeout got=%b/%0d/%b/%h exp=1/4/%b/%h",
                     seen, nstb, bus4.p1_err, bus4.p1_rdata, e.err, e.rdata);
        end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        bus.p0_valid = 1'b0; bus.p0_write = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0;
        bus.p1_valid = 1'b0; bus.p1_write = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0;
        bus4.p0_valid = 1'b0; bus4.p0_write = 1'b0; bus4.p0_addr = '0; bus4.p0_wdata = '0;
        bus4.p1_valid = 1'b0; bus4.p1_write = 1'b0; bus4.p1_addr = '0; bus4.p1_wdata = '0;
        bus4.mem_ready = 1'b0; bus4.mem_data_out = '0;
        test_reset();
        test_read();
        test_alternation();
        test_write();
        test_timeout();
        test_reset_mid();
        test_ready_on_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
